// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a DEPTH-entry byte FIFO feeding a START/DATA/STOP
// serialiser, with a one-cycle tx_data_valid strobe at each frame start.
module uart_tx_fifo #(
  parameter int DEPTH    = 8,
  parameter int BAUD_DIV = 434
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [7:0]                 wr_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       busy,
  output logic                       tx_pin,
  output logic                       tx_data_valid,
  output logic [7:0]                 tx_data,
  output logic [1:0]                 fsm_state
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);
  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  // Write side is valid-only: wr_en offers a byte every cycle it is high, there is no
  // ready; a byte offered while full (and no pop in the same cycle) is dropped.
  state_e          state_q, state_d;
  logic [7:0]      mem_q [DEPTH];
  logic [7:0]      mem_d [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic [CW-1:0]   baud_cnt_q, baud_cnt_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shifter_q, shifter_d;
  logic            tx_pin_q, tx_pin_d;
  logic            tx_data_valid_q, tx_data_valid_d;
  logic [7:0]      tx_data_q, tx_data_d;

  logic fifo_full, fifo_empty, pop, push, bit_end;

  assign fifo_full  = (level_q == LW'(DEPTH));
  assign fifo_empty = (level_q == '0);
  assign pop        = (state_q == IDLE) && !fifo_empty;
  assign push       = wr_en && (!fifo_full || pop);
  assign bit_end    = (state_q != IDLE) && (baud_cnt_q == CW'(BAUD_DIV - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!fifo_empty) state_d = START;
      START:   if (bit_end) state_d = DATA;
      DATA:    if (bit_end && (bit_cnt_q == 3'd7)) state_d = STOP;
      STOP:    if (bit_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_d           = mem_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    level_d         = level_q;
    bit_cnt_d       = bit_cnt_q;
    shifter_d       = shifter_q;
    tx_pin_d        = tx_pin_q;
    tx_data_d       = tx_data_q;
    tx_data_valid_d = pop;
    baud_cnt_d      = (state_q == IDLE || bit_end) ? '0 : baud_cnt_q + CW'(1);

    if (push) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    case (state_q)
      IDLE: begin
        tx_pin_d = 1'b1;
        if (pop) begin
          shifter_d = mem_q[rd_ptr_q];
          tx_data_d = mem_q[rd_ptr_q];
          tx_pin_d  = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          bit_cnt_d = 3'd0;
          tx_pin_d  = shifter_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_cnt_q == 3'd7) begin
            tx_pin_d = 1'b1;
          end else begin
            // The next bit to drive is already sitting one place up in the shifter.
            shifter_d = {1'b0, shifter_q[7:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
            tx_pin_d  = shifter_q[1];
          end
        end
      end
      STOP:    tx_pin_d = 1'b1;
      default: tx_pin_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q           <= '{default: '0};
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      level_q         <= '0;
      baud_cnt_q      <= '0;
      bit_cnt_q       <= '0;
      shifter_q       <= '0;
      tx_pin_q        <= 1'b1;
      tx_data_valid_q <= 1'b0;
      tx_data_q       <= 8'h00;
    end else begin
      mem_q           <= mem_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      level_q         <= level_d;
      baud_cnt_q      <= baud_cnt_d;
      bit_cnt_q       <= bit_cnt_d;
      shifter_q       <= shifter_d;
      tx_pin_q        <= tx_pin_d;
      tx_data_valid_q <= tx_data_valid_d;
      tx_data_q       <= tx_data_d;
    end
  end

  always_comb begin
    full          = fifo_full;
    empty         = fifo_empty;
    level         = level_q;
    busy          = (state_q != IDLE);
    tx_pin        = tx_pin_q;
    tx_data_valid = tx_data_valid_q;
    tx_data       = tx_data_q;
    fsm_state     = state_q;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo (DEPTH=4, BAUD_DIV=4): lockstep frame-timing model plus
// directed frame tables and corner-case sequences.
module tb_uart_tx_fifo;
  localparam int DEPTH = 4;
  localparam int BAUD  = 4;
  localparam int FRAME = 10 * BAUD;
  localparam int LW    = $clog2(DEPTH + 1);

  logic          clk;
  logic          rst;
  logic          wr_en;
  logic [7:0]    wr_data;
  logic          full;
  logic          empty;
  logic [LW-1:0] level;
  logic          busy;
  logic          tx_pin;
  logic          tx_data_valid;
  logic [7:0]    tx_data;
  logic [1:0]    fsm_state;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int dut_max_level = 0;

  logic [7:0] exp_q[$];
  logic [7:0] strobe_log[$];
  int         strobe_cyc[$];

  logic [7:0] m_q[$];
  int         m_left  = 0;
  logic [7:0] m_cur   = 8'h00;
  logic [7:0] m_data  = 8'h00;
  logic       m_valid = 1'b0;

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
  } vec_t;
  vec_t vecs[5];

  uart_tx_fifo #(.DEPTH(DEPTH), .BAUD_DIV(BAUD)) dut (
    .clk           (clk),
    .rst           (rst),
    .wr_en         (wr_en),
    .wr_data       (wr_data),
    .full          (full),
    .empty         (empty),
    .level         (level),
    .busy          (busy),
    .tx_pin        (tx_pin),
    .tx_data_valid (tx_data_valid),
    .tx_data       (tx_data),
    .fsm_state     (fsm_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic write_byte(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (!(busy == 1'b0 && empty == 1'b1) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk(name, (n < 2000), 1);
    repeat (2) @(negedge clk);
  endtask

  // Reference: a byte queue plus a frame timer; the line level is derived from how far
  // into the 10-bit frame {stop, data, start} the timer has progressed.
  initial begin : ref_model
    logic       s_wr;
    logic [7:0] s_d;
    logic       pop;
    logic [9:0] fr;
    int         idx;
    logic       exp_pin;
    logic [7:0] want;
    forever begin
      @(posedge clk);
      cyc++;
      s_wr = wr_en;
      s_d  = wr_data;
      if (!rst) begin
        m_q.delete();
        exp_q.delete();
        m_left  = 0;
        m_valid = 1'b0;
        m_data  = 8'h00;
        m_cur   = 8'h00;
      end else begin
        pop = (m_left == 0) && (m_q.size() > 0);
        if (m_left > 0) m_left--;
        m_valid = pop;
        if (pop) begin
          m_cur  = m_q.pop_front();
          m_data = m_cur;
          m_left = FRAME;
          exp_q.push_back(m_cur);
        end
        if (s_wr && m_q.size() < DEPTH) m_q.push_back(s_d);
      end
      #1;
      if (m_left == 0) begin
        exp_pin = 1'b1;
      end else begin
        fr      = {1'b1, m_cur, 1'b0};
        idx     = (FRAME - m_left) / BAUD;
        exp_pin = fr[idx];
      end
      chk("tx_pin", tx_pin, exp_pin);
      chk("busy", busy, (m_left > 0));
      chk("level", level, m_q.size());
      chk("full", full, (m_q.size() == DEPTH));
      chk("empty", empty, (m_q.size() == 0));
      chk("tx_data_valid", tx_data_valid, m_valid);
      chk("tx_data", tx_data, m_data);
      if (int'(level) > dut_max_level) dut_max_level = int'(level);
      if (tx_data_valid) begin
        strobe_log.push_back(tx_data);
        strobe_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_unexpected_strobe: got strobe with data %0h, required no strobe", tx_data);
        end else begin
          want = exp_q.pop_front();
          chk("sb_data", tx_data, want);
        end
      end
    end
  end

  initial begin : main
    int base;
    int n;
    vecs[0] = '{8'h55, 10'b1010101010};
    vecs[1] = '{8'h0F, 10'b1000011110};
    vecs[2] = '{8'h00, 10'b1000000000};
    vecs[3] = '{8'h81, 10'b1100000010};
    vecs[4] = '{8'hA5, 10'b1101001010};

    rst     = 1'b0;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_tx_pin", tx_pin, 1);
    chk("rst_busy", busy, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_level", level, 0);
    chk("rst_valid", tx_data_valid, 0);
    chk("rst_tx_data", tx_data, 8'h00);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Single frames against hand-written line waveforms.
    for (int i = 0; i < 5; i++) begin
      write_byte(vecs[i].data);
      @(negedge clk);
      chk("vec_strobe", tx_data_valid, 1);
      chk("vec_data", tx_data, vecs[i].data);
      for (int k = 0; k < FRAME; k++) begin
        chk("vec_pin", tx_pin, vecs[i].frame[k / BAUD]);
        @(negedge clk);
      end
      chk("vec_end_busy", busy, 0);
      chk("vec_end_pin", tx_pin, 1);
      wait_idle("vec_idle_timeout");
    end

    // Back-to-back frames.
    base = strobe_log.size();
    wr_en = 1'b1; wr_data = 8'hA5; @(negedge clk);
    wr_data = 8'h3C; @(negedge clk);
    wr_data = 8'hFF; @(negedge clk);
    wr_en = 1'b0;
    wait_idle("b2b_timeout");
    chk("b2b_count", strobe_log.size() - base, 3);
    if (strobe_log.size() - base == 3) begin
      chk("b2b_d0", strobe_log[base], 8'hA5);
      chk("b2b_d1", strobe_log[base + 1], 8'h3C);
      chk("b2b_d2", strobe_log[base + 2], 8'hFF);
      chk("b2b_gap0", strobe_cyc[base + 1] - strobe_cyc[base], FRAME + 1);
      chk("b2b_gap1", strobe_cyc[base + 2] - strobe_cyc[base + 1], FRAME + 1);
    end
    chk("b2b_level", level, 0);

    // Overfill while the first frame is in flight.
    base = strobe_log.size();
    dut_max_level = 0;
    write_byte(8'h11);
    @(negedge clk);
    for (int i = 0; i < 5; i++) write_byte(8'h12 + 8'(i));
    chk("ovf_full", full, 1);
    chk("ovf_level", level, DEPTH);
    wait_idle("ovf_timeout");
    chk("ovf_count", strobe_log.size() - base, 5);
    if (strobe_log.size() - base == 5)
      for (int i = 0; i < 5; i++) chk("ovf_data", strobe_log[base + i], 8'h11 + 8'(i));
    chk("ovf_max_level", (dut_max_level <= DEPTH), 1);

    // Push into a full FIFO in the same cycle the idle FSM pops.
    base = strobe_log.size();
    write_byte(8'h21);
    @(negedge clk);
    for (int i = 0; i < 4; i++) write_byte(8'h22 + 8'(i));
    n = 0;
    while (!(busy == 1'b0 && full == 1'b1) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("pp_reach_idle_full", (n < 100), 1);
    write_byte(8'hC3);
    chk("pp_level", level, DEPTH);
    chk("pp_full", full, 1);
    wait_idle("pp_timeout");
    chk("pp_count", strobe_log.size() - base, 6);
    if (strobe_log.size() - base == 6) chk("pp_last", strobe_log[base + 5], 8'hC3);

    // Asynchronous reset in the middle of data bit 3.
    write_byte(8'h0F);
    write_byte(8'h77);
    chk("ar_strobe", tx_data_valid, 1);
    chk("ar_data", tx_data, 8'h0F);
    repeat (17) @(negedge clk);
    chk("ar_busy_pre", busy, 1);
    chk("ar_level_pre", level, 1);
    #2 rst = 1'b0;
    #1;
    chk("ar_pin", tx_pin, 1);
    chk("ar_busy", busy, 0);
    chk("ar_empty", empty, 1);
    chk("ar_level", level, 0);
    chk("ar_valid", tx_data_valid, 0);
    chk("ar_tx_data", tx_data, 8'h00);
    @(negedge clk);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    base = strobe_log.size();
    repeat (60) @(negedge clk);
    chk("ar_no_strobe", strobe_log.size() - base, 0);
    chk("ar_idle_pin", tx_pin, 1);

    // Random traffic at several write densities.
    for (int ph = 0; ph < 3; ph++) begin
      for (int c = 0; c < 500; c++) begin
        wr_en   = ($urandom_range(0, 99) < (ph == 0 ? 5 : (ph == 1 ? 30 : 90)));
        wr_data = 8'($urandom_range(0, 255));
        @(negedge clk);
      end
    end
    wr_en = 1'b0;
    wait_idle("rand_drain_timeout");
    chk("rand_sb_drained", exp_q.size(), 0);

    // Quiet line.
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      chk("quiet_pin", tx_pin, 1);
      chk("quiet_valid", tx_data_valid, 0);
      chk("quiet_busy", busy, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
